// File: rtl/seq_detector_1101.sv
// rtl/seq_detector_1101.sv - overlapping 1-1-0-1 serial pattern detector (Moore FSM)
module seq_detector_1101 (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic detected
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] S1   = 3'd1;
   localparam logic [2:0] S2   = 3'd2;
   localparam logic [2:0] S3   = 3'd3;
   localparam logic [2:0] S4   = 3'd4;

   logic [2:0] state;
   logic [2:0] state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Each state is the longest suffix of the input history that is a prefix of 1101.
   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:    state_next = in ? S1 : IDLE;
         S1:      state_next = in ? S2 : IDLE;
         S2:      state_next = in ? S2 : S3;
         S3:      state_next = in ? S4 : IDLE;
         S4:      state_next = in ? S2 : IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign detected = (state == S4);

endmodule

// File: tb/tb_seq_detector_1101.sv
// tb/tb_seq_detector_1101.sv - self-checking bench for seq_detector_1101
module tb_seq_detector_1101;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in  = 1'b0;
   logic detected;

   int checks   = 0;
   int failures = 0;

   // Reference: bits sampled since the last reset, as a history window plus a count.
   logic [3:0] hist = 4'b0000;
   int         nbits = 0;

   seq_detector_1101 dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in),
      .detected (detected)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist  <= 4'b0000;
         nbits <= 0;
      end else begin
         hist  <= {hist[2:0], in};
         nbits <= nbits + 1;
      end
   end

   function automatic logic model_det();
      return (nbits >= 4) && (hist == 4'b1101);
   endfunction

   always @(negedge clk) begin
      checks = checks + 1;
      if (detected !== model_det()) begin
         failures = failures + 1;
         $display("FAIL model_cycle t=%0t detected=%b expected=%b", $time, detected, model_det());
      end
   end

   task automatic check_lit(input logic exp, input string name);
      checks = checks + 1;
      if (detected !== exp) begin
         failures = failures + 1;
         $display("FAIL %s detected=%b expected=%b", name, detected, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      in = b;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin
         in = $urandom_range(0, 1);
         @(posedge clk);
         #1;
      end
      check_lit(1'b0, "reset_hold");
      rst = 1'b0;
   endtask

   // bits and exp are MSB-first; exp[k] is detected after sending bit k.
   task automatic run_stream(input logic [7:0] bits, input logic [7:0] exp, input int n,
                             input string name);
      for (int i = n - 1; i >= 0; i--) begin
         send_bit(bits[i]);
         check_lit(exp[i], name);
      end
   endtask

   initial begin
      #1;
      @(posedge clk);
      #1;
      check_lit(1'b0, "reset_state");
      do_reset();
      #3;
      check_lit(1'b0, "reset_release_no_spurious");

      run_stream(8'b0000_1101, 8'b0000_0001, 4, "basic_match");
      run_stream(8'b0000_0101, 8'b0000_0001, 3, "overlap_match");
      send_bit(1'b0);
      check_lit(1'b0, "after_overlap");

      do_reset();
      run_stream(8'b0001_1101, 8'b0000_0001, 6, "long_run_prefix");

      do_reset();
      run_stream(8'b0000_1100, 8'b0, 4, "near_1100");
      do_reset();
      run_stream(8'b0000_1001, 8'b0, 4, "near_1001");
      do_reset();
      run_stream(8'b0000_1010, 8'b0, 4, "near_1010");
      do_reset();
      run_stream(8'b0000_0000, 8'b0, 4, "near_0000");
      do_reset();
      run_stream(8'b0000_1111, 8'b0, 4, "near_1111");

      do_reset();
      run_stream(8'b0000_0110, 8'b0, 3, "mid_prefix");
      rst = 1'b1;
      #2;
      check_lit(1'b0, "async_reset_mid");
      rst = 1'b0;
      run_stream(8'b0000_0001, 8'b0, 1, "partial_discarded");
      run_stream(8'b0000_1101, 8'b0000_0001, 4, "match_after_reset");

      // Reaching S4 then asserting rst between edges must clear detected without a clock.
      rst = 1'b1;
      #2;
      check_lit(1'b0, "async_reset_clears_detect");
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_bit(1'b0);
      check_lit(1'b0, "idle_after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
